// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared state encoding, widths and helpers for the alarm
//                annunciator slice.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SOUNDING = 2'b01;
    localparam logic [1:0] ST_SNOOZE   = 2'b10;
    localparam logic [1:0] ST_MUTED    = 2'b11;

    localparam int ALERT_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE     = ST_IDLE,
        S_SOUNDING = ST_SOUNDING,
        S_SNOOZE   = ST_SNOOZE,
        S_MUTED    = ST_MUTED
    } alarm_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fall_detect.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fall_detect
//  Description : Two-flop synchroniser plus history flop; emits a one-cycle
//                pulse on each falling edge of an asynchronous active-low input.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fall_detect
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async_n,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // All flops reset to the released (high) level so reset exit never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_async_n;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_fall = r_hist & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/alarm_annunciator.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_annunciator
//  Description : Drives buzzer tone and blinking LED from the alarm FSM alert,
//                with acknowledge-driven snooze/mute and a saturating event count.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int TONE_DIV      = 4,
    parameter int BLINK_DIV     = 16,
    parameter int SNOOZE_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alert_i,
    input  logic                   ack_n_i,
    output logic                   buzzer_o,
    output logic                   led_o,
    output logic                   sounding_o,
    output logic [ALERT_CNT_W-1:0] alert_count_o
);

    localparam int c_tone_w   = cnt_width(TONE_DIV);
    localparam int c_blink_w  = cnt_width(BLINK_DIV);
    localparam int c_snooze_w = cnt_width(SNOOZE_CYCLES);

    localparam logic [c_tone_w-1:0]   c_tone_max   = c_tone_w'(TONE_DIV - 1);
    localparam logic [c_blink_w-1:0]  c_blink_max  = c_blink_w'(BLINK_DIV - 1);
    localparam logic [c_snooze_w-1:0] c_snooze_max = c_snooze_w'(SNOOZE_CYCLES - 1);

    alarm_state_t r_state;
    alarm_state_t w_next_state;

    logic w_ack_pulse;
    logic w_enter_sounding;
    logic w_enter_snooze;
    logic w_count_event;

    logic [c_tone_w-1:0]    r_tone_cnt;
    logic [c_blink_w-1:0]   r_blink_cnt;
    logic [c_snooze_w-1:0]  r_snooze_cnt;
    logic                   r_buzzer;
    logic                   r_led;
    logic [ALERT_CNT_W-1:0] r_alert_cnt;

    sync_fall_detect u_ack_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_async_n (ack_n_i),
        .o_fall    (w_ack_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Alert deassertion outranks acknowledge, which outranks snooze expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (alert_i) begin
                    w_next_state = S_SOUNDING;
                end
            end
            S_SOUNDING: begin
                if (!alert_i) begin
                    w_next_state = S_IDLE;
                end else if (w_ack_pulse) begin
                    w_next_state = S_SNOOZE;
                end
            end
            S_SNOOZE: begin
                if (!alert_i) begin
                    w_next_state = S_IDLE;
                end else if (w_ack_pulse) begin
                    w_next_state = S_MUTED;
                end else if (r_snooze_cnt == '0) begin
                    w_next_state = S_SOUNDING;
                end
            end
            S_MUTED: begin
                if (!alert_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_enter_sounding = (w_next_state == S_SOUNDING) && (r_state != S_SOUNDING);
    assign w_enter_snooze   = (w_next_state == S_SNOOZE)   && (r_state != S_SNOOZE);
    assign w_count_event    = (r_state == S_IDLE) && (w_next_state == S_SOUNDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snooze_cnt <= '0;
        end else if (w_enter_snooze) begin
            r_snooze_cnt <= c_snooze_max;
        end else if ((r_state == S_SNOOZE) && (w_next_state == S_SNOOZE)) begin
            r_snooze_cnt <= r_snooze_cnt - c_snooze_w'(1);
        end else begin
            r_snooze_cnt <= '0;
        end
    end

    // Outputs are registered against the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt  <= '0;
            r_blink_cnt <= '0;
            r_buzzer    <= 1'b0;
            r_led       <= 1'b0;
        end else if (w_next_state == S_SOUNDING) begin
            if (w_enter_sounding) begin
                r_tone_cnt  <= '0;
                r_blink_cnt <= '0;
                r_buzzer    <= 1'b0;
                r_led       <= 1'b0;
            end else begin
                if (r_tone_cnt == c_tone_max) begin
                    r_tone_cnt <= '0;
                    r_buzzer   <= ~r_buzzer;
                end else begin
                    r_tone_cnt <= r_tone_cnt + c_tone_w'(1);
                end
                if (r_blink_cnt == c_blink_max) begin
                    r_blink_cnt <= '0;
                    r_led       <= ~r_led;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
                end
            end
        end else begin
            r_tone_cnt  <= '0;
            r_blink_cnt <= '0;
            r_buzzer    <= 1'b0;
            r_led       <= (w_next_state == S_SNOOZE) || (w_next_state == S_MUTED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alert_cnt <= '0;
        end else if (w_count_event && (r_alert_cnt != '1)) begin
            r_alert_cnt <= r_alert_cnt + ALERT_CNT_W'(1);
        end
    end

    assign buzzer_o      = r_buzzer;
    assign led_o         = r_led;
    assign sounding_o    = (r_state == S_SOUNDING);
    assign alert_count_o = r_alert_cnt;

endmodule
`default_nettype wire
